// File: rtl/dice_roll_ctrl.sv
// Roll sequencer for five dice: shuffles unheld dice from a free-running LFSR for a
// fixed number of frames, then freezes them; owns the per-turn hold mask and roll count.
module dice_roll_ctrl #(
    parameter int          ANIM_FRAMES = 8,
    parameter int          FRAME_DIV   = 4,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        turn_start,
    input  logic        roll_trigger,
    input  logic [4:0]  hold_toggle,
    output logic [14:0] dice_flat,
    output logic [4:0]  hold_mask,
    output logic [1:0]  roll_cnt,
    output logic        busy,
    output logic        roll_done,
    output logic        dice_valid
);
    localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int FRM_W = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(FRAME_DIV - 1);
    localparam logic [FRM_W-1:0] FRM_LAST  = FRM_W'(ANIM_FRAMES - 1);
    localparam logic [15:0]      LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {IDLE, ANIM, DONE} state_t;

    state_t           state_reg, state_next;
    logic [15:0]      lfsr_reg, lfsr_next;
    logic [DIV_W-1:0] div_reg, div_next;
    logic [FRM_W-1:0] frm_reg, frm_next;
    logic [14:0]      dice_reg, dice_next;
    logic [4:0]       hold_reg, hold_next;
    logic [1:0]       cnt_reg, cnt_next;
    logic             valid_reg, valid_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic [14:0]      rand_flat;
    logic [14:0]      held_bits;
    logic             frame_tick;

    assign lfsr_next  = (lfsr_reg >> 1) ^ (lfsr_reg[0] ? LFSR_TAPS : 16'h0000);
    assign frame_tick = (div_reg == DIV_LAST);

    // Each die reads its own 3-bit LFSR slice; values 6 and 7 wrap onto faces 1 and 2.
    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_die
            logic [2:0] v;
            assign v = lfsr_reg[3*gi +: 3];
            assign rand_flat[3*gi +: 3] = (v >= 3'd6) ? (v - 3'd5) : (v + 3'd1);
            assign held_bits[3*gi +: 3] = {3{hold_reg[gi]}};
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        div_next   = div_reg;
        frm_next   = frm_reg;
        dice_next  = dice_reg;
        hold_next  = hold_reg;
        cnt_next   = cnt_reg;
        valid_next = valid_reg;

        case (state_reg)
            IDLE: begin
                if (roll_trigger && (cnt_reg != 2'd3)) begin
                    state_next = ANIM;
                    div_next   = '0;
                    frm_next   = '0;
                end else if (valid_reg) begin
                    hold_next = hold_reg ^ hold_toggle;
                end
            end
            ANIM: begin
                if (frame_tick) begin
                    div_next  = '0;
                    dice_next = (dice_reg & held_bits) | (rand_flat & ~held_bits);
                    if (frm_reg == FRM_LAST) begin
                        state_next = DONE;
                    end else begin
                        frm_next = frm_reg + FRM_W'(1);
                    end
                end else begin
                    div_next = div_reg + DIV_W'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
                cnt_next   = (cnt_reg == 2'd3) ? cnt_reg : cnt_reg + 2'd1;
                valid_next = 1'b1;
            end
            default: state_next = IDLE;
        endcase

        // A turn boundary wins over everything, including an in-flight roll.
        if (turn_start) begin
            state_next = IDLE;
            dice_next  = '0;
            hold_next  = '0;
            cnt_next   = '0;
            valid_next = 1'b0;
        end
    end

    assign busy_next = (state_next == ANIM);
    assign done_next = (state_next == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            lfsr_reg  <= LFSR_SEED;
            div_reg   <= '0;
            frm_reg   <= '0;
            dice_reg  <= '0;
            hold_reg  <= '0;
            cnt_reg   <= '0;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            lfsr_reg  <= lfsr_next;
            div_reg   <= div_next;
            frm_reg   <= frm_next;
            dice_reg  <= dice_next;
            hold_reg  <= hold_next;
            cnt_reg   <= cnt_next;
            valid_reg <= valid_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    assign dice_flat  = dice_reg;
    assign hold_mask  = hold_reg;
    assign roll_cnt   = cnt_reg;
    assign busy       = busy_reg;
    assign roll_done  = done_reg;
    assign dice_valid = valid_reg;
endmodule

// File: tb/tb_dice_roll_ctrl.sv
// Bench for dice_roll_ctrl: a time-based turn model is compared against the DUT every
// cycle, alongside directed scenarios with hand-derived expectations.
module tb_dice_roll_ctrl;
    localparam int          ANIM_FRAMES = 8;
    localparam int          FRAME_DIV   = 4;
    localparam logic [15:0] LFSR_SEED   = 16'hACE1;
    localparam int          ROLL_LEN    = ANIM_FRAMES * FRAME_DIV;

    logic        clk;
    logic        reset;
    logic        turn_start;
    logic        roll_trigger;
    logic [4:0]  hold_toggle;
    logic [14:0] dice_flat;
    logic [4:0]  hold_mask;
    logic [1:0]  roll_cnt;
    logic        busy;
    logic        roll_done;
    logic        dice_valid;

    int checks = 0;
    int errors = 0;

    dice_roll_ctrl #(
        .ANIM_FRAMES(ANIM_FRAMES),
        .FRAME_DIV  (FRAME_DIV),
        .LFSR_SEED  (LFSR_SEED)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .turn_start  (turn_start),
        .roll_trigger(roll_trigger),
        .hold_toggle (hold_toggle),
        .dice_flat   (dice_flat),
        .hold_mask   (hold_mask),
        .roll_cnt    (roll_cnt),
        .busy        (busy),
        .roll_done   (roll_done),
        .dice_valid  (dice_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    function automatic logic [2:0] face_of(input logic [2:0] v);
        int x;
        x = int'(v);
        return 3'((x % 6) + 1);
    endfunction

    function automatic logic [2:0] die(input logic [14:0] f, input int i);
        return f[3*i +: 3];
    endfunction

    // Model: tracks elapsed clocks since the accepted trigger instead of an FSM state.
    logic [15:0] m_lfsr, m_cur;
    logic [14:0] m_dice;
    logic [4:0]  m_hold;
    int          m_cnt, m_t, m_updates;
    bit          m_valid, m_rolling;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_lfsr = LFSR_SEED; m_dice = '0; m_hold = '0;
            m_cnt = 0; m_valid = 0; m_rolling = 0; m_t = 0;
        end else begin
            m_cur  = m_lfsr;
            m_lfsr = lfsr_step(m_cur);
            if (turn_start) begin
                m_dice = '0; m_hold = '0; m_cnt = 0; m_valid = 0; m_rolling = 0;
            end else if (m_rolling) begin
                m_t++;
                if (m_t <= ROLL_LEN && (m_t % FRAME_DIV) == 0) begin
                    for (int i = 0; i < 5; i++)
                        if (!m_hold[i]) m_dice[3*i +: 3] = face_of(m_cur[3*i +: 3]);
                    m_updates++;
                end
                if (m_t == ROLL_LEN + 1) begin
                    m_rolling = 0;
                    if (m_cnt < 3) m_cnt++;
                    m_valid = 1;
                end
            end else if (roll_trigger && m_cnt < 3) begin
                m_rolling = 1; m_t = 0; m_updates = 0;
            end else if (m_valid) begin
                m_hold ^= hold_toggle;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("model dice_flat", 32'(dice_flat), 32'(m_dice));
            chk("model hold_mask", 32'(hold_mask), 32'(m_hold));
            chk("model roll_cnt", 32'(roll_cnt), 32'(m_cnt));
            chk("model dice_valid", 32'(dice_valid), 32'(m_valid));
            chk("model busy", 32'(busy), 32'(m_rolling && m_t < ROLL_LEN));
            chk("model roll_done", 32'(roll_done), 32'(m_rolling && m_t == ROLL_LEN));
        end
    end

    task automatic step(input logic ts, input logic rt, input logic [4:0] ht);
        turn_start = ts; roll_trigger = rt; hold_toggle = ht;
        @(negedge clk);
        turn_start = 1'b0; roll_trigger = 1'b0; hold_toggle = 5'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Entered at the negedge of cycle 'start' after the trigger edge (cycle 1 = just after it).
    task automatic wait_roll(input string tag, input int start);
        int n, bc, dc;
        n = start - 1; bc = start - 1; dc = 0;
        while (n < 200 && dc == 0) begin
            n++;
            if (busy) bc++;
            if (roll_done) dc = n;
            else @(negedge clk);
        end
        chk({tag, " busy_len"}, 32'(bc), 32'(ROLL_LEN));
        chk({tag, " done_cycle"}, 32'(dc), 32'(ROLL_LEN + 1));
        chk({tag, " model_updates"}, 32'(m_updates), 32'(ANIM_FRAMES));
        for (int i = 0; i < 5; i++)
            chk({tag, " face_range"}, 32'(die(dice_flat, i) >= 3'd1 && die(dice_flat, i) <= 3'd6), 32'd1);
        $display("%s: faces=%0d %0d %0d %0d %0d hold=%b done_cycle=%0d", tag,
                 die(dice_flat, 0), die(dice_flat, 1), die(dice_flat, 2),
                 die(dice_flat, 3), die(dice_flat, 4), hold_mask, dc);
        @(negedge clk);
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, " dice_flat"}, 32'(dice_flat), 32'd0);
        chk({tag, " hold_mask"}, 32'(hold_mask), 32'd0);
        chk({tag, " roll_cnt"}, 32'(roll_cnt), 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " roll_done"}, 32'(roll_done), 32'd0);
        chk({tag, " dice_valid"}, 32'(dice_valid), 32'd0);
    endtask

    initial begin
        logic [15:0] s;
        logic [2:0]  map_tbl [8];
        logic [14:0] first_faces, keep;
        int          seen;

        reset = 1'b1; turn_start = 1'b0; roll_trigger = 1'b0; hold_toggle = 5'b0;

        // Pin the model helpers with hand-worked values.
        map_tbl = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd1, 3'd2};
        for (int v = 0; v < 8; v++) chk("map_pin", 32'(face_of(3'(v))), 32'(map_tbl[v]));
        s = lfsr_step(LFSR_SEED);
        chk("lfsr_pin1", 32'(s), 32'h0000E270);
        for (int k = 0; k < 3; k++) s = lfsr_step(s);
        chk("lfsr_pin4", 32'(s), 32'h00001C4E);

        #2;
        chk_cleared("reset");
        idle(2);
        reset = 1'b0;

        // Roll 1 from a fresh turn.
        idle(3); step(1, 0, 5'b0); idle(2);
        step(0, 1, 5'b0);
        wait_roll("roll1", 1);
        first_faces = dice_flat;
        chk("roll1 cnt", 32'(roll_cnt), 32'd1);
        chk("roll1 valid", 32'(dice_valid), 32'd1);

        // Holds on dice 0 and 2.
        step(0, 0, 5'b00101);
        chk("hold set", 32'(hold_mask), 32'b00101);
        keep = dice_flat;
        step(0, 1, 5'b0);
        wait_roll("roll2", 1);
        chk("held die0", 32'(die(dice_flat, 0)), 32'(die(keep, 0)));
        chk("held die2", 32'(die(dice_flat, 2)), 32'(die(keep, 2)));
        chk("roll2 cnt", 32'(roll_cnt), 32'd2);
        step(0, 0, 5'b00001);
        chk("hold toggle", 32'(hold_mask), 32'b00100);

        // Third roll, then a fourth trigger that must be ignored.
        step(0, 1, 5'b0);
        wait_roll("roll3", 1);
        chk("roll3 cnt", 32'(roll_cnt), 32'd3);
        step(0, 1, 5'b0);
        chk("roll4 ignored busy", 32'(busy), 32'd0);
        idle(3);
        chk("roll4 ignored busy later", 32'(busy), 32'd0);
        chk("roll4 cnt sat", 32'(roll_cnt), 32'd3);

        // New turn: holds ignored before the first roll and while busy.
        step(1, 0, 5'b0);
        chk_cleared("turn2");
        step(0, 0, 5'b00011);
        chk("hold before roll", 32'(hold_mask), 32'd0);
        step(0, 1, 5'b00011);
        chk("trig+hold busy", 32'(busy), 32'd1);
        chk("trig+hold mask", 32'(hold_mask), 32'd0);
        idle(3);
        step(0, 0, 5'b10000);
        chk("hold during busy", 32'(hold_mask), 32'd0);
        wait_roll("roll5", 5);

        // All five held: full-length roll, faces frozen.
        step(0, 0, 5'b11111);
        chk("hold all", 32'(hold_mask), 32'b11111);
        keep = dice_flat;
        step(0, 1, 5'b0);
        wait_roll("roll6", 1);
        chk("all held faces", 32'(dice_flat), 32'(keep));
        chk("all held cnt", 32'(roll_cnt), 32'd2);

        // Abort at cycle 10 of an animation.
        step(0, 0, 5'b11101);
        chk("hold before abort", 32'(hold_mask), 32'b00010);
        step(0, 1, 5'b0);
        idle(8);
        step(1, 0, 5'b0);
        chk_cleared("abort");
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (roll_done) seen++;
            @(negedge clk);
        end
        chk("abort no roll_done", 32'(seen), 32'd0);

        // Asynchronous reset in the middle of a roll.
        step(1, 0, 5'b0);
        step(0, 1, 5'b0);
        idle(5);
        #2 reset = 1'b1;
        #1;
        chk_cleared("async reset");
        idle(2);
        reset = 1'b0;
        idle(3); step(1, 0, 5'b0); idle(2);
        step(0, 1, 5'b0);
        wait_roll("roll_after_reset", 1);
        chk("replay faces", 32'(dice_flat), 32'(first_faces));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
